// File: rtl/cve2_obi_mem_responder.sv
// OBI-style memory responder: byte-enabled word array with in-order, fixed-latency responses.
// Optional pseudo-random grant back-pressure when CVE2_MEM_STALL_EN is defined.
module cve2_obi_mem_responder #(
    parameter int unsigned MemWords       = 1024,
    parameter logic [31:0] BaseAddr       = 32'h0000_0000,
    parameter int unsigned RespLatency    = 1,
    parameter int unsigned MaxOutstanding = 2,
    parameter logic [15:0] StallSeed      = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int unsigned AW = $clog2(MemWords);
    localparam int unsigned PW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned NW = $clog2(MaxOutstanding + 1);
    localparam logic [32:0]    LIMIT    = {1'b0, BaseAddr} + 33'(4 * MemWords);
    localparam logic [2:0]     CNT_INIT = 3'(RespLatency - 1);
    localparam logic [PW-1:0]  LAST_PTR = PW'(MaxOutstanding - 1);
    localparam logic [NW-1:0]  MAX_CNT  = NW'(MaxOutstanding);

    logic [31:0]               r_mem    [MemWords];
    logic [31:0]               r_q_data [MaxOutstanding];
    logic                      r_q_err  [MaxOutstanding];
    logic [2:0]                r_q_cnt  [MaxOutstanding];
    logic [MaxOutstanding-1:0] r_q_vld;
    logic [PW-1:0]             r_wrptr;
    logic [PW-1:0]             r_rdptr;
    logic [NW-1:0]             r_count;

    logic          w_err;
    logic [AW-1:0] w_idx;
    logic          w_pop;
    logic          w_stall;
    logic          w_gnt;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

`ifdef CVE2_MEM_STALL_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lfsr <= StallSeed;
        end else begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
    assign w_stall = 1'b0;
`endif

    // BaseAddr is 4*MemWords aligned, so the word index is just the low address bits.
    assign w_err = ({1'b0, addr_i} < {1'b0, BaseAddr}) || ({1'b0, addr_i} >= LIMIT);
    assign w_idx = addr_i[AW+1:2];

    // Only the head can reach cnt==0 first, since entries are pushed in grant order.
    assign w_pop = r_q_vld[r_rdptr] && (r_q_cnt[r_rdptr] == '0);

    always_comb begin
        w_gnt = req_i && rst_ni && ((r_count < MAX_CNT) || w_pop) && !w_stall;
    end

    assign gnt_o    = w_gnt;
    assign rvalid_o = w_pop;
    assign rdata_o  = w_pop ? r_q_data[r_rdptr] : '0;
    assign err_o    = w_pop && r_q_err[r_rdptr];

    always_ff @(posedge clk_i) begin
        if (w_gnt && we_i && !w_err) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    r_mem[w_idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_q_vld <= '0;
            r_wrptr <= '0;
            r_rdptr <= '0;
            r_count <= '0;
            for (int unsigned i = 0; i < MaxOutstanding; i++) begin
                r_q_data[i] <= '0;
                r_q_err[i]  <= 1'b0;
                r_q_cnt[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < MaxOutstanding; i++) begin
                if (r_q_vld[i] && (r_q_cnt[i] != '0)) begin
                    r_q_cnt[i] <= r_q_cnt[i] - 3'd1;
                end
            end
            if (w_pop) begin
                r_q_vld[r_rdptr] <= 1'b0;
                r_rdptr          <= f_next(r_rdptr);
            end
            // Push after pop so a full queue draining this cycle reuses the freed slot.
            if (w_gnt) begin
                r_q_vld[r_wrptr]  <= 1'b1;
                r_q_data[r_wrptr] <= (!we_i && !w_err) ? r_mem[w_idx] : '0;
                r_q_err[r_wrptr]  <= w_err;
                r_q_cnt[r_wrptr]  <= CNT_INIT;
                r_wrptr           <= f_next(r_wrptr);
            end
            case ({w_gnt, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) r_count <= MAX_CNT);

endmodule

// File: tb/tb_cve2_obi_mem_responder.sv
// Scoreboard bench: DUT A (latency 1, 1024 words at 0) and DUT B (latency 4, 16 words at 0x1000_0000).
// Stall-ratio scenario is built only when CVE2_MEM_STALL_EN is defined.
module tb_cve2_obi_mem_responder;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          c;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
    logic [31:0] addr_a = '0, wdata_a = '0, addr_b = '0, wdata_b = '0;
    logic [3:0]  be_a = '0, be_b = '0;
    logic        gnt_a, rvalid_a, err_a, gnt_b, rvalid_b, err_b;
    logic [31:0] rdata_a, rdata_b;

    logic [31:0] m_a [1024];
    logic [31:0] m_b [16];
    rsp_t qa[$], qb[$], oa[$], ob[$];
    int   gcyc_b[$];
    int   cyc = 0;
    int   occ_b = 0, max_b = 0;
    logic ga, gb;
    int   checks = 0, errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cve2_obi_mem_responder #(
        .MemWords(1024), .BaseAddr(32'h0000_0000), .RespLatency(1),
        .MaxOutstanding(2), .StallSeed(16'hACE1)
    ) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_a), .gnt_o(gnt_a), .addr_i(addr_a),
        .we_i(we_a), .be_i(be_a), .wdata_i(wdata_a), .rvalid_o(rvalid_a),
        .rdata_o(rdata_a), .err_o(err_a)
    );

    cve2_obi_mem_responder #(
        .MemWords(16), .BaseAddr(32'h1000_0000), .RespLatency(4),
        .MaxOutstanding(2), .StallSeed(16'hACE1)
    ) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_b), .gnt_o(gnt_b), .addr_i(addr_b),
        .we_i(we_b), .be_i(be_b), .wdata_i(wdata_b), .rvalid_o(rvalid_b),
        .rdata_o(rdata_b), .err_o(err_b)
    );

    // One clock: sample at negedge, record responses, push expectations for grants.
    task automatic tick();
        logic [31:0] d;
        logic        e;
        @(negedge clk);
        ga = gnt_a;
        gb = gnt_b;
        if (rvalid_a) oa.push_back('{rdata_a, err_a, cyc});
        if (rvalid_b) begin
            ob.push_back('{rdata_b, err_b, cyc});
            occ_b--;
        end
        if (req_a && gnt_a) begin
            e = (addr_a >= 32'h0000_1000);
            d = '0;
            if (we_a) begin
                if (!e) for (int b = 0; b < 4; b++) if (be_a[b]) m_a[addr_a[11:2]][8*b +: 8] = wdata_a[8*b +: 8];
            end else if (!e) begin
                d = m_a[addr_a[11:2]];
            end
            qa.push_back('{d, e, cyc + 1});
        end
        if (req_b && gnt_b) begin
            e = (addr_b < 32'h1000_0000) || (addr_b >= 32'h1000_0040);
            d = '0;
            if (we_b) begin
                if (!e) for (int b = 0; b < 4; b++) if (be_b[b]) m_b[addr_b[5:2]][8*b +: 8] = wdata_b[8*b +: 8];
            end else if (!e) begin
                d = m_b[addr_b[5:2]];
            end
            qb.push_back('{d, e, cyc + 4});
            gcyc_b.push_back(cyc);
            occ_b++;
        end
        if (occ_b > max_b) max_b = occ_b;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit sel_b, input logic w, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] d, output int n);
        if (sel_b) begin
            req_b = 1'b1; we_b = w; addr_b = a; be_b = be; wdata_b = d;
        end else begin
            req_a = 1'b1; we_a = w; addr_a = a; be_a = be; wdata_a = d;
        end
        n = 0;
        do begin
            tick();
            n++;
        end while (!(sel_b ? gb : ga) && n < 64);
        if (!(sel_b ? gb : ga)) begin
            checks++; errors++;
            $display("FAIL grant_timeout sel_b=%0d addr=%h waited %0d cycles", sel_b, a, n);
        end
    endtask

    task automatic drain();
        req_a = 1'b0;
        req_b = 1'b0;
        for (int i = 0; i < 64 && (oa.size() < qa.size() || ob.size() < qb.size()); i++) tick();
        repeat (3) tick();
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        req_a = 1'b1; we_a = 1'b1; addr_a = 32'h20; be_a = 4'hF; wdata_a = 32'hCAFE_F00D;
        req_b = 1'b1; we_b = 1'b0; addr_b = 32'h1000_0000; be_b = 4'hF;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({gnt_a, gnt_b, rvalid_a, rvalid_b, err_a, err_b} !== 6'b0 || rdata_a !== '0 || rdata_b !== '0) begin
                errors++;
                $display("FAIL reset_outputs got gnt=%b%b rvalid=%b%b err=%b%b rdata_a=%h expected all zero",
                         gnt_a, gnt_b, rvalid_a, rvalid_b, err_a, err_b, rdata_a);
            end
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        req_b = 1'b0;
        issue(0, 1'b1, 32'h20, 4'hF, 32'hCAFE_F00D, n);
`ifndef CVE2_MEM_STALL_EN
        checks++;
        if (n !== 1) begin
            errors++;
            $display("FAIL reset_first_grant got %0d cycles expected 1", n);
        end
`endif
        issue(0, 1'b0, 32'h20, 4'hF, 32'h0, n);
        drain();
        while (qa.size() != 0) begin
            rsp_t ex, ob_r;
            ex = qa.pop_front();
            checks++;
            if (oa.size() == 0) begin
                errors++; $display("FAIL reset_resp missing expected d=%h e=%b c=%0d", ex.d, ex.e, ex.c);
            end else begin
                ob_r = oa.pop_front();
                if (ob_r.d !== ex.d || ob_r.e !== ex.e || ob_r.c !== ex.c) begin
                    errors++; $display("FAIL reset_resp got d=%h e=%b c=%0d expected d=%h e=%b c=%0d",
                                       ob_r.d, ob_r.e, ob_r.c, ex.d, ex.e, ex.c);
                end
            end
        end
        checks++;
        if (oa.size() != 0) begin errors++; $display("FAIL reset_extra got %0d expected 0", oa.size()); end
        oa.delete();
    endtask

    task automatic test_rw();
        int n;
        issue(0, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, n);
        issue(0, 1'b0, 32'h10, 4'hF, 32'h0, n);
        issue(0, 1'b1, 32'h3FC, 4'hF, 32'h0BAD_F00D, n);
        issue(0, 1'b0, 32'h3FC, 4'hF, 32'h0, n);
        issue(0, 1'b0, 32'h10, 4'hF, 32'h0, n);
        drain();
        while (qa.size() != 0) begin
            rsp_t ex, ob_r;
            ex = qa.pop_front();
            checks++;
            if (oa.size() == 0) begin
                errors++; $display("FAIL rw_resp missing expected d=%h e=%b c=%0d", ex.d, ex.e, ex.c);
            end else begin
                ob_r = oa.pop_front();
                if (ob_r.d !== ex.d || ob_r.e !== ex.e || ob_r.c !== ex.c) begin
                    errors++; $display("FAIL rw_resp got d=%h e=%b c=%0d expected d=%h e=%b c=%0d",
                                       ob_r.d, ob_r.e, ob_r.c, ex.d, ex.e, ex.c);
                end
            end
        end
        checks++;
        if (oa.size() != 0) begin errors++; $display("FAIL rw_extra got %0d expected 0", oa.size()); end
        oa.delete();
    endtask

    task automatic test_byte_enable();
        int n;
        issue(0, 1'b1, 32'h10, 4'b0101, 32'h1122_3344, n);
        issue(0, 1'b0, 32'h10, 4'hF, 32'h0, n);
        issue(0, 1'b1, 32'h10, 4'b0000, 32'hFFFF_FFFF, n);
        issue(0, 1'b0, 32'h10, 4'b0000, 32'h0, n);
        issue(0, 1'b1, 32'h14, 4'b1010, 32'hA1B2_C3D4, n);
        issue(0, 1'b0, 32'h14, 4'hF, 32'h0, n);
        drain();
        while (qa.size() != 0) begin
            rsp_t ex, ob_r;
            ex = qa.pop_front();
            checks++;
            if (oa.size() == 0) begin
                errors++; $display("FAIL be_resp missing expected d=%h e=%b c=%0d", ex.d, ex.e, ex.c);
            end else begin
                ob_r = oa.pop_front();
                if (ob_r.d !== ex.d || ob_r.e !== ex.e || ob_r.c !== ex.c) begin
                    errors++; $display("FAIL be_resp got d=%h e=%b c=%0d expected d=%h e=%b c=%0d",
                                       ob_r.d, ob_r.e, ob_r.c, ex.d, ex.e, ex.c);
                end
            end
        end
        checks++;
        if (oa.size() != 0) begin errors++; $display("FAIL be_extra got %0d expected 0", oa.size()); end
        oa.delete();
    endtask

    task automatic test_error();
        int n;
        issue(0, 1'b1, 32'hFFC, 4'hF, 32'h5A5A_1234, n);
        issue(0, 1'b0, 32'h1000, 4'hF, 32'h0, n);
        issue(0, 1'b1, 32'h1000, 4'hF, 32'hFFFF_FFFF, n);
        issue(0, 1'b0, 32'hFFC, 4'hF, 32'h0, n);
        issue(0, 1'b0, 32'hFFFF_FFFC, 4'hF, 32'h0, n);
        drain();
        while (qa.size() != 0) begin
            rsp_t ex, ob_r;
            ex = qa.pop_front();
            checks++;
            if (oa.size() == 0) begin
                errors++; $display("FAIL err_resp missing expected d=%h e=%b c=%0d", ex.d, ex.e, ex.c);
            end else begin
                ob_r = oa.pop_front();
                if (ob_r.d !== ex.d || ob_r.e !== ex.e || ob_r.c !== ex.c) begin
                    errors++; $display("FAIL err_resp got d=%h e=%b c=%0d expected d=%h e=%b c=%0d",
                                       ob_r.d, ob_r.e, ob_r.c, ex.d, ex.e, ex.c);
                end
            end
        end
        checks++;
        if (oa.size() != 0) begin errors++; $display("FAIL err_extra got %0d expected 0", oa.size()); end
        oa.delete();
    endtask

    task automatic test_back_pressure();
        int n;
        int g[$];
        for (int i = 0; i < 6; i++) issue(1, 1'b1, 32'h1000_0000 + 4*i, 4'hF, 32'h0101_0101 * (i + 1), n);
        drain();
        gcyc_b.delete();
        max_b = 0;
        for (int i = 0; i < 6; i++) issue(1, 1'b0, 32'h1000_0000 + 4*(5 - i), 4'hF, 32'h0, n);
        issue(1, 1'b0, 32'h1000_0040, 4'hF, 32'h0, n);
        drain();
        g = gcyc_b;
`ifndef CVE2_MEM_STALL_EN
        checks++;
        if (g.size() != 7 || g[1] != g[0] + 1 || g[2] != g[0] + 4 || g[3] != g[0] + 5) begin
            errors++;
            $display("FAIL bp_grant_cycles got offsets %0d %0d %0d expected 1 4 5",
                     g[1] - g[0], g[2] - g[0], g[3] - g[0]);
        end
`endif
        checks++;
        if (max_b != 2) begin errors++; $display("FAIL bp_max_outstanding got %0d expected 2", max_b); end
        while (qb.size() != 0) begin
            rsp_t ex, ob_r;
            ex = qb.pop_front();
            checks++;
            if (ob.size() == 0) begin
                errors++; $display("FAIL bp_resp missing expected d=%h e=%b c=%0d", ex.d, ex.e, ex.c);
            end else begin
                ob_r = ob.pop_front();
                if (ob_r.d !== ex.d || ob_r.e !== ex.e || ob_r.c !== ex.c) begin
                    errors++; $display("FAIL bp_resp got d=%h e=%b c=%0d expected d=%h e=%b c=%0d",
                                       ob_r.d, ob_r.e, ob_r.c, ex.d, ex.e, ex.c);
                end
            end
        end
        checks++;
        if (ob.size() != 0) begin errors++; $display("FAIL bp_extra got %0d expected 0", ob.size()); end
        ob.delete();
    endtask

    task automatic test_reset_mid();
        int n;
        issue(1, 1'b0, 32'h1000_0004, 4'hF, 32'h0, n);
        issue(1, 1'b0, 32'h1000_0008, 4'hF, 32'h0, n);
        req_b = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (rvalid_b !== 1'b0 || gnt_b !== 1'b0) begin
            errors++; $display("FAIL mid_reset_outputs got rvalid=%b gnt=%b expected 0 0", rvalid_b, gnt_b);
        end
        @(posedge clk);
        #1;
        tick();
        rst_n = 1'b1;
        qb.delete();
        ob.delete();
        occ_b = 0;
        repeat (8) tick();
        checks++;
        if (ob.size() != 0) begin errors++; $display("FAIL mid_reset_rvalid got %0d responses expected 0", ob.size()); end
        ob.delete();
        issue(1, 1'b0, 32'h1000_0014, 4'hF, 32'h0, n);
        drain();
        while (qb.size() != 0) begin
            rsp_t ex, ob_r;
            ex = qb.pop_front();
            checks++;
            if (ob.size() == 0) begin
                errors++; $display("FAIL mid_resp missing expected d=%h e=%b c=%0d", ex.d, ex.e, ex.c);
            end else begin
                ob_r = ob.pop_front();
                if (ob_r.d !== ex.d || ob_r.e !== ex.e || ob_r.c !== ex.c) begin
                    errors++; $display("FAIL mid_resp got d=%h e=%b c=%0d expected d=%h e=%b c=%0d",
                                       ob_r.d, ob_r.e, ob_r.c, ex.d, ex.e, ex.c);
                end
            end
        end
        checks++;
        if (ob.size() != 0) begin errors++; $display("FAIL mid_extra got %0d expected 0", ob.size()); end
        ob.delete();
    endtask

`ifdef CVE2_MEM_STALL_EN
    task automatic test_stall();
        int n;
        int req_cyc = 0, stall_cyc = 0;
        for (int i = 0; i < 64; i++) issue(0, 1'b1, 32'h400 + 4*i, 4'hF, 32'h3C00_0000 + i, n);
        drain();
        qa.delete();
        oa.delete();
        for (int i = 0; i < 1000; i++) begin
            issue(0, 1'b0, 32'h400 + 4*(i % 64), 4'hF, 32'h0, n);
            req_cyc += n;
            stall_cyc += n - 1;
        end
        drain();
        checks++;
        if (stall_cyc * 100 < req_cyc * 20 || stall_cyc * 100 > req_cyc * 30) begin
            errors++; $display("FAIL stall_ratio got %0d/%0d stalled expected 20-30%%", stall_cyc, req_cyc);
        end
        while (qa.size() != 0) begin
            rsp_t ex, ob_r;
            ex = qa.pop_front();
            checks++;
            if (oa.size() == 0) begin
                errors++; $display("FAIL stall_resp missing expected d=%h e=%b c=%0d", ex.d, ex.e, ex.c);
            end else begin
                ob_r = oa.pop_front();
                if (ob_r.d !== ex.d || ob_r.e !== ex.e || ob_r.c !== ex.c) begin
                    errors++; $display("FAIL stall_resp got d=%h e=%b c=%0d expected d=%h e=%b c=%0d",
                                       ob_r.d, ob_r.e, ob_r.c, ex.d, ex.e, ex.c);
                end
            end
        end
        checks++;
        if (oa.size() != 0) begin errors++; $display("FAIL stall_extra got %0d expected 0", oa.size()); end
        oa.delete();
    endtask
`endif

    initial begin
        #1;
        test_reset();
        test_rw();
        test_byte_enable();
        test_error();
        test_back_pressure();
        test_reset_mid();
`ifdef CVE2_MEM_STALL_EN
        test_stall();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

endmodule
